// File: rtl/axilite_rr_arbiter.sv
// axilite_rr_arbiter: round-robin arbiter that shares one AXI4-Lite slave port between two masters.
//   ACLK, ARESET        clock, synchronous active-high reset
//   S0_AXI_*, S1_AXI_*  upstream AXI4-Lite slave ports (AW, W, B, AR, R channels)
//   M_AXI_*             downstream AXI4-Lite master port
//   GRANT               one-hot owner of the current transaction, 2'b00 while idle
//   Optional macro AXILITE_RR_ARBITER_STATS_EN adds STAT_TXN0/STAT_TXN1/STAT_CONFLICT counters.
module axilite_rr_arbiter #(
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S0_AXI_AWADDR,
    input  logic                          S0_AXI_AWVALID,
    output logic                          S0_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S0_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S0_AXI_WSTRB,
    input  logic                          S0_AXI_WVALID,
    output logic                          S0_AXI_WREADY,
    output logic [1:0]                    S0_AXI_BRESP,
    output logic                          S0_AXI_BVALID,
    input  logic                          S0_AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S0_AXI_ARADDR,
    input  logic                          S0_AXI_ARVALID,
    output logic                          S0_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S0_AXI_RDATA,
    output logic [1:0]                    S0_AXI_RRESP,
    output logic                          S0_AXI_RVALID,
    input  logic                          S0_AXI_RREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S1_AXI_AWADDR,
    input  logic                          S1_AXI_AWVALID,
    output logic                          S1_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   S1_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] S1_AXI_WSTRB,
    input  logic                          S1_AXI_WVALID,
    output logic                          S1_AXI_WREADY,
    output logic [1:0]                    S1_AXI_BRESP,
    output logic                          S1_AXI_BVALID,
    input  logic                          S1_AXI_BREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   S1_AXI_ARADDR,
    input  logic                          S1_AXI_ARVALID,
    output logic                          S1_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   S1_AXI_RDATA,
    output logic [1:0]                    S1_AXI_RRESP,
    output logic                          S1_AXI_RVALID,
    input  logic                          S1_AXI_RREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY,
`ifdef AXILITE_RR_ARBITER_STATS_EN
    output logic [31:0]                   STAT_TXN0,
    output logic [31:0]                   STAT_TXN1,
    output logic [15:0]                   STAT_CONFLICT,
`endif
    output logic [1:0]                    GRANT
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;
    state_t state, state_n;
    logic [1:0] grant_n;
    logic last_grant, last_n, aw_done, aw_done_n, w_done, w_done_n;
    logic sel, in_ar, in_r, in_aw, in_b;
    logic ar_valid, aw_valid, w_valid, r_ready, b_ready;
    logic ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs, aw_fin, w_fin;
    logic req0, req1, win1;
    assign sel = GRANT[1];
    assign in_ar = state == RD_ADDR;
    assign in_r = state == RD_DATA;
    assign in_aw = state == WR_ADDR;
    assign in_b = state == WR_RESP;
    assign ar_valid = sel ? S1_AXI_ARVALID : S0_AXI_ARVALID;
    assign aw_valid = sel ? S1_AXI_AWVALID : S0_AXI_AWVALID;
    assign w_valid = sel ? S1_AXI_WVALID : S0_AXI_WVALID;
    assign r_ready = sel ? S1_AXI_RREADY : S0_AXI_RREADY;
    assign b_ready = sel ? S1_AXI_BREADY : S0_AXI_BREADY;
    assign M_AXI_ARADDR = sel ? S1_AXI_ARADDR : S0_AXI_ARADDR;
    assign M_AXI_AWADDR = sel ? S1_AXI_AWADDR : S0_AXI_AWADDR;
    assign M_AXI_WDATA = sel ? S1_AXI_WDATA : S0_AXI_WDATA;
    assign M_AXI_WSTRB = sel ? S1_AXI_WSTRB : S0_AXI_WSTRB;
    // A channel that already handshook is masked so it cannot transfer twice.
    assign M_AXI_ARVALID = in_ar & ar_valid;
    assign M_AXI_AWVALID = in_aw & ~aw_done & aw_valid;
    assign M_AXI_WVALID = in_aw & ~w_done & w_valid;
    assign M_AXI_RREADY = in_r & r_ready;
    assign M_AXI_BREADY = in_b & b_ready;
    assign ar_rdy = in_ar & M_AXI_ARREADY;
    assign aw_rdy = in_aw & ~aw_done & M_AXI_AWREADY;
    assign w_rdy = in_aw & ~w_done & M_AXI_WREADY;
    assign r_vld = in_r & M_AXI_RVALID;
    assign b_vld = in_b & M_AXI_BVALID;
    assign S0_AXI_ARREADY = GRANT[0] & ar_rdy;
    assign S0_AXI_AWREADY = GRANT[0] & aw_rdy;
    assign S0_AXI_WREADY = GRANT[0] & w_rdy;
    assign S0_AXI_RVALID = GRANT[0] & r_vld;
    assign S0_AXI_BVALID = GRANT[0] & b_vld;
    assign S1_AXI_ARREADY = GRANT[1] & ar_rdy;
    assign S1_AXI_AWREADY = GRANT[1] & aw_rdy;
    assign S1_AXI_WREADY = GRANT[1] & w_rdy;
    assign S1_AXI_RVALID = GRANT[1] & r_vld;
    assign S1_AXI_BVALID = GRANT[1] & b_vld;
    assign S0_AXI_RDATA = M_AXI_RDATA;
    assign S1_AXI_RDATA = M_AXI_RDATA;
    assign S0_AXI_RRESP = M_AXI_RRESP;
    assign S1_AXI_RRESP = M_AXI_RRESP;
    assign S0_AXI_BRESP = M_AXI_BRESP;
    assign S1_AXI_BRESP = M_AXI_BRESP;
    assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
    assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs = M_AXI_WVALID & M_AXI_WREADY;
    assign r_hs = M_AXI_RVALID & M_AXI_RREADY;
    assign b_hs = M_AXI_BVALID & M_AXI_BREADY;
    assign aw_fin = aw_done | aw_hs;
    assign w_fin = w_done | w_hs;
    assign req0 = S0_AXI_ARVALID | S0_AXI_AWVALID;
    assign req1 = S1_AXI_ARVALID | S1_AXI_AWVALID;
    // last_grant=1 means S1 was served last, so S0 wins a tie.
    assign win1 = req1 & (~req0 | ~last_grant);
    always_comb begin
        state_n = state;
        grant_n = GRANT;
        last_n = last_grant;
        aw_done_n = aw_done;
        w_done_n = w_done;
        case (state)
            IDLE: if (req0 | req1) begin
                grant_n = {win1, ~win1};
                state_n = (win1 ? S1_AXI_ARVALID : S0_AXI_ARVALID) ? RD_ADDR : WR_ADDR;
            end
            RD_ADDR: if (ar_hs) state_n = RD_DATA;
            RD_DATA: if (r_hs) begin
                last_n = sel;
                grant_n = 2'b00;
                state_n = IDLE;
            end
            WR_ADDR: if (aw_fin & w_fin) begin
                aw_done_n = 1'b0;
                w_done_n = 1'b0;
                state_n = WR_RESP;
            end else begin
                aw_done_n = aw_fin;
                w_done_n = w_fin;
            end
            WR_RESP: if (b_hs) begin
                last_n = sel;
                grant_n = 2'b00;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= IDLE;
            GRANT <= 2'b00;
            last_grant <= 1'b1;
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else begin
            state <= state_n;
            GRANT <= grant_n;
            last_grant <= last_n;
            aw_done <= aw_done_n;
            w_done <= w_done_n;
        end
    end
`ifdef AXILITE_RR_ARBITER_STATS_EN
    logic done_hs;
    assign done_hs = r_hs | b_hs;
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            STAT_TXN0 <= '0;
            STAT_TXN1 <= '0;
            STAT_CONFLICT <= '0;
        end else begin
            if (done_hs & ~sel & ~&STAT_TXN0) STAT_TXN0 <= STAT_TXN0 + 32'd1;
            if (done_hs & sel & ~&STAT_TXN1) STAT_TXN1 <= STAT_TXN1 + 32'd1;
            if (state == IDLE & req0 & req1 & ~&STAT_CONFLICT) STAT_CONFLICT <= STAT_CONFLICT + 16'd1;
        end
    end
`endif
endmodule
